// File: rtl/timer_control.sv
// Keypad-driven countdown timer / stopwatch with BCD display and an alarm
// that auto-clears after ALARM_TICKS seconds. All outputs are registered.
module timer_control #(
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        tick_1hz,
    input  logic        mode_down,
    output logic [15:0] disp,
    output logic [2:0]  state,
    output logic        running,
    output logic        alarm,
    output logic        done_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_entry, w_entry_next;
    logic [15:0] r_count, w_count_next;
    logic [15:0] r_limit, w_limit_next;
    logic        r_mode_down, w_mode_down_next;
    logic [7:0]  r_alarm_cnt, w_alarm_cnt_next;
    logic [15:0] r_disp;
    logic        r_running, r_alarm, r_done_pulse;

    logic        w_key_digit, w_key_hash, w_key_clear;
    logic [15:0] w_dec, w_inc;
    logic [3:0]  w_borrow, w_carry;
    logic [7:0]  w_alarm_inc;

    assign w_key_digit = key_valid && (key_code <= 4'd9);
    assign w_key_hash  = key_valid && (key_code == 4'd10);
    assign w_key_clear = key_valid && (key_code == 4'd11);
    assign w_alarm_inc = r_alarm_cnt + 8'd1;

    // Ripple BCD decrement/increment of the count, one digit per generate slice.
    assign w_borrow[0] = 1'b1;
    assign w_carry[0]  = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [3:0] w_digit;
            assign w_digit = r_count[gi*4 +: 4];
            assign w_dec[gi*4 +: 4] = !w_borrow[gi] ? w_digit :
                                      (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
            assign w_inc[gi*4 +: 4] = !w_carry[gi] ? w_digit :
                                      (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
            if (gi < 3) begin : g_chain
                assign w_borrow[gi+1] = w_borrow[gi] && (w_digit == 4'd0);
                assign w_carry[gi+1]  = w_carry[gi]  && (w_digit == 4'd9);
            end
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_entry_next     = r_entry;
        w_count_next     = r_count;
        w_limit_next     = r_limit;
        w_mode_down_next = r_mode_down;
        w_alarm_cnt_next = r_alarm_cnt;
        if (w_key_clear) begin
            w_state_next = ST_IDLE;
            w_entry_next = 16'h0000;
            w_count_next = 16'h0000;
            w_limit_next = 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    if (w_key_digit) begin
                        w_entry_next = {r_entry[11:0], key_code};
                        w_state_next = ST_ENTRY;
                    end else if (w_key_hash) begin
                        if (mode_down) begin
                            if (r_entry != 16'h0000) begin
                                w_count_next     = r_entry;
                                w_mode_down_next = 1'b1;
                                w_state_next     = ST_RUN;
                            end
                        end else begin
                            w_count_next     = 16'h0000;
                            w_limit_next     = (r_entry == 16'h0000) ? 16'h9999 : r_entry;
                            w_mode_down_next = 1'b0;
                            w_state_next     = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // '#' swallows a coincident tick; other keys let it through.
                    if (w_key_hash) begin
                        w_state_next = ST_PAUSE;
                    end else if (tick_1hz) begin
                        w_count_next = r_mode_down ? w_dec : w_inc;
                        if (r_mode_down ? (w_dec == 16'h0000) : (w_inc == r_limit)) begin
                            w_state_next     = ST_DONE;
                            w_alarm_cnt_next = 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_key_hash) w_state_next = ST_RUN;
                end
                ST_DONE: begin
                    if (key_valid) begin
                        w_state_next = ST_IDLE;
                        w_entry_next = 16'h0000;
                        w_count_next = 16'h0000;
                    end else if (tick_1hz) begin
                        if (w_alarm_inc == 8'(ALARM_TICKS)) begin
                            w_state_next = ST_IDLE;
                            w_entry_next = 16'h0000;
                            w_count_next = 16'h0000;
                        end else begin
                            w_alarm_cnt_next = w_alarm_inc;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_entry      <= 16'h0000;
            r_count      <= 16'h0000;
            r_limit      <= 16'h0000;
            r_mode_down  <= 1'b0;
            r_alarm_cnt  <= 8'd0;
            r_disp       <= 16'h0000;
            r_running    <= 1'b0;
            r_alarm      <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_entry      <= w_entry_next;
            r_count      <= w_count_next;
            r_limit      <= w_limit_next;
            r_mode_down  <= w_mode_down_next;
            r_alarm_cnt  <= w_alarm_cnt_next;
            r_disp       <= (w_state_next == ST_IDLE || w_state_next == ST_ENTRY) ?
                            w_entry_next : w_count_next;
            r_running    <= (w_state_next == ST_RUN);
            r_alarm      <= (w_state_next == ST_DONE);
            r_done_pulse <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
        end
    end

    assign disp       = r_disp;
    assign state      = r_state;
    assign running    = r_running;
    assign alarm      = r_alarm;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_timer_control.sv
// Directed table-driven bench for timer_control: each vector is one clock
// cycle of inputs plus the outputs expected just after that edge.
module tb_timer_control;

    localparam logic [3:0] H = 4'd10;  // '#'
    localparam logic [3:0] S = 4'd11;  // '*'

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  kc;
        logic        tk;
        logic        md;
        logic [15:0] disp;
        logic [2:0]  st;
        logic        run;
        logic        alm;
        logic        dp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        tick_1hz = 1'b0;
    logic        mode_down = 1'b0;
    logic [15:0] disp;
    logic [2:0]  state;
    logic        running, alarm, done_pulse;

    int checks = 0;
    int errors = 0;
    int row = 0;
    vec_t tbl[$];

    timer_control #(.ALARM_TICKS(5)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .tick_1hz(tick_1hz), .mode_down(mode_down), .disp(disp), .state(state),
        .running(running), .alarm(alarm), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic kv, input logic [3:0] kc,
                                input logic tk, input logic md, input logic [15:0] d,
                                input logic [2:0] st, input logic run, input logic alm,
                                input logic dp);
        vec_t v;
        v.rst = r; v.kv = kv; v.kc = kc; v.tk = tk; v.md = md;
        v.disp = d; v.st = st; v.run = run; v.alm = alm; v.dp = dp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp_v);
        end
    endtask

    task automatic step(input vec_t v);
        rst = v.rst; key_valid = v.kv; key_code = v.kc; tick_1hz = v.tk; mode_down = v.md;
        @(posedge clk);
        #1;
        chk("disp", disp, v.disp);
        chk("state", 16'(state), 16'(v.st));
        chk("running", 16'(running), 16'(v.run));
        chk("alarm", 16'(alarm), 16'(v.alm));
        chk("done_pulse", 16'(done_pulse), 16'(v.dp));
        $display("row %0d rst=%0b kv=%0b kc=%0d tick=%0b md=%0b -> disp=%h state=%0d run=%0b alarm=%0b dp=%0b",
                 row, v.rst, v.kv, v.kc, v.tk, v.md, disp, state, running, alarm, done_pulse);
        row++;
    endtask

    initial begin
        // Reset and five-digit entry wrap
        tbl.push_back(mk(1,0,0,0,0, 16'h0000,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 16'h0001,1,0,0,0));
        tbl.push_back(mk(0,1,2,0,0, 16'h0012,1,0,0,0));
        tbl.push_back(mk(0,1,3,0,0, 16'h0123,1,0,0,0));
        tbl.push_back(mk(0,1,4,0,0, 16'h1234,1,0,0,0));
        tbl.push_back(mk(0,1,5,0,0, 16'h2345,1,0,0,0));
        tbl.push_back(mk(0,1,12,0,0, 16'h2345,1,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h2345,1,0,0,0));
        tbl.push_back(mk(0,1,S,0,0, 16'h0000,0,0,0,0));
        // Countdown from 3 into DONE, alarm expires after 5 ticks
        tbl.push_back(mk(0,1,3,0,1, 16'h0003,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0003,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0002,2,1,0,0));
        tbl.push_back(mk(0,1,7,0,1, 16'h0002,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0001,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0000,4,0,1,1));
        tbl.push_back(mk(0,0,0,0,1, 16'h0000,4,0,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,1,1, 16'h0000,4,0,1,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0000,0,0,0,0));
        // Borrow 0100 -> 0099; '#' on zero entry ignored
        tbl.push_back(mk(0,1,1,0,1, 16'h0001,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 16'h0010,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 16'h0100,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0100,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0099,2,1,0,0));
        tbl.push_back(mk(0,1,S,0,1, 16'h0000,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 16'h0000,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0000,1,0,0,0));
        // Stopwatch to limit 0002; key in DONE consumed
        tbl.push_back(mk(0,1,2,0,0, 16'h0002,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,0, 16'h0000,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0001,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0002,4,0,1,1));
        tbl.push_back(mk(0,1,7,0,0, 16'h0000,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,0, 16'h0005,1,0,0,0));
        tbl.push_back(mk(0,1,S,0,0, 16'h0000,0,0,0,0));
        // Pause/resume, '#'+tick, other key+tick, mode_down change mid-run
        tbl.push_back(mk(0,1,5,0,1, 16'h0005,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,1, 16'h0050,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0050,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0049,2,1,0,0));
        tbl.push_back(mk(0,1,H,1,1, 16'h0049,3,0,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0049,3,0,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0049,3,0,0,0));
        tbl.push_back(mk(0,1,3,0,1, 16'h0049,3,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0049,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0048,2,1,0,0));
        tbl.push_back(mk(0,1,4,1,1, 16'h0047,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0046,2,1,0,0));
        tbl.push_back(mk(0,1,S,1,0, 16'h0000,0,0,0,0));
        // Reset mid-RUN at 0042, '*' mid-ENTRY, reset mid-DONE
        tbl.push_back(mk(0,1,4,0,1, 16'h0004,1,0,0,0));
        tbl.push_back(mk(0,1,3,0,1, 16'h0043,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,1, 16'h0043,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 16'h0042,2,1,0,0));
        tbl.push_back(mk(1,1,H,1,1, 16'h0000,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,1, 16'h0001,1,0,0,0));
        tbl.push_back(mk(0,1,2,0,1, 16'h0012,1,0,0,0));
        tbl.push_back(mk(0,1,S,0,1, 16'h0000,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 16'h0001,1,0,0,0));
        tbl.push_back(mk(0,1,H,0,0, 16'h0000,2,1,0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0001,4,0,1,1));
        tbl.push_back(mk(1,0,0,1,0, 16'h0000,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Stopwatch to 0009 through single-digit increments
        step(mk(0,1,9,0,0, 16'h0009,1,0,0,0));
        step(mk(0,1,H,0,0, 16'h0000,2,1,0,0));
        for (int k = 1; k <= 9; k++)
            step(mk(0,0,0,1,0, {12'h000, 4'(k)}, (k == 9) ? 3'd4 : 3'd2,
                    (k != 9), (k == 9), (k == 9)));
        step(mk(0,1,S,0,0, 16'h0000,0,0,0,0));

        // Limit 0099: ten ticks carry into the tens digit
        step(mk(0,1,9,0,0, 16'h0009,1,0,0,0));
        step(mk(0,1,9,0,0, 16'h0099,1,0,0,0));
        step(mk(0,1,H,0,0, 16'h0000,2,1,0,0));
        for (int k = 1; k <= 10; k++)
            step(mk(0,0,0,1,0, (k == 10) ? 16'h0010 : {12'h000, 4'(k)}, 3'd2, 1'b1, 1'b0, 1'b0));
        step(mk(0,1,S,0,0, 16'h0000,0,0,0,0));

        // Borrow across three digits: 1000 -> 0999 -> 0998
        step(mk(0,1,1,0,1, 16'h0001,1,0,0,0));
        for (int k = 0; k < 3; k++) step(mk(0,1,0,0,1, (k == 0) ? 16'h0010 : (k == 1) ? 16'h0100 : 16'h1000,1,0,0,0));
        step(mk(0,1,H,0,1, 16'h1000,2,1,0,0));
        step(mk(0,0,0,1,1, 16'h0999,2,1,0,0));
        step(mk(0,0,0,1,1, 16'h0998,2,1,0,0));
        step(mk(0,1,12,0,1, 16'h0998,2,1,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
